// File: rtl/tx_ring_pkg.sv
// Shared types and helpers for the TX packet ring writer.
package tx_ring_pkg;

  localparam int SLOT_BYTES_DEF = 2048;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SOP  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  // Descriptor handed to the DMA side: slot base byte address and length.
  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] len;
  } desc_t;

  // Byte count of a keep mask; callers zero-extend narrower masks to 16 bits.
  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/tx_desc_fifo.sv
// First-word-fall-through descriptor FIFO with a synchronous flush.
// The writer never pushes more entries than there are ring slots, so the
// FIFO has no full flag.
module tx_desc_fifo
  import tx_ring_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  push,
  input  desc_t din,
  input  logic  pop,
  output desc_t dout,
  output logic  valid
);
  localparam int AW = $clog2(DEPTH);

  desc_t      r_mem [DEPTH];
  logic [AW:0] r_wp;
  logic [AW:0] r_rp;
  logic        w_empty;

  assign w_empty = (r_wp == r_rp);
  assign valid   = ~w_empty;
  assign dout    = r_mem[r_rp[AW-1:0]];

  // Pointer update; flush wins over a simultaneous push or pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (push)             r_wp <= r_wp + 1'b1;
      if (pop && !w_empty)  r_rp <= r_rp + 1'b1;
    end
  end

  // Storage is not reset; empty entries are never presented as valid.
  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tx_packet_ring_writer.sv
// AXIS Ethernet packets into a BRAM ring of fixed-size slots. Good packets
// produce a descriptor; oversize or tuser-errored packets are dropped and
// counted. Slots are returned by explicit release pulses from the DMA side.
module tx_packet_ring_writer
  import tx_ring_pkg::*;
#(
  parameter int S_WIDTH    = 64,
  parameter int DATA_WIDTH = 128,
  parameter int NB_TX_DESC = 64,
  parameter int SLOT_BYTES = SLOT_BYTES_DEF,
  parameter int ERR_BIT    = 0
) (
  input  logic                            axi_clk,
  input  logic                            axi_reset,
  input  logic [S_WIDTH-1:0]              s_axis_eth_tdata,
  input  logic [7:0]                      s_axis_eth_tuser,
  input  logic                            s_axis_eth_tlast,
  input  logic [S_WIDTH/8-1:0]            s_axis_eth_tkeep,
  input  logic                            s_axis_eth_tvalid,
  output logic                            s_axis_eth_tready,
  output logic                            clk_o,
  output logic [31:0]                     addr_o,
  output logic [DATA_WIDTH-1:0]           data_o,
  output logic [DATA_WIDTH/8-1:0]         wea_o,
  output logic                            en_o,
  output logic                            wren_o,
  input  logic                            init_i,
  input  logic                            start_i,
  output logic [31:0]                     pkt_addr_o,
  output logic [15:0]                     pkt_len_o,
  output logic                            pkt_valid_o,
  input  logic                            pkt_ready_i,
  input  logic                            pkt_release_i,
  output logic [$clog2(NB_TX_DESC):0]     slots_used_o,
  output logic [31:0]                     drop_cnt_o
);
  localparam int R   = DATA_WIDTH / S_WIDTH;
  localparam int KB  = S_WIDTH / 8;
  localparam int RB  = DATA_WIDTH / 8;
  localparam int PW  = $clog2(NB_TX_DESC);
  localparam int RSH = $clog2(R);
  localparam int LW  = (R > 1) ? RSH : 1;

  state_e                r_state, w_state_nxt;
  logic                  r_init_pend;
  logic [PW:0]           r_wr_ptr, r_rel_ptr;
  logic [15:0]           r_bytes, r_beat;
  logic [31:0]           r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [RB-1:0]         r_wea;
  logic                  r_en;
  logic [31:0]           r_drop;

  logic        w_init_any, w_slot_free, w_tready, w_acc, w_in_pkt;
  logic        w_over, w_err, w_wr, w_good, w_drop, w_rel;
  logic [PW:0] w_used;
  logic [15:0] w_keep16, w_new_bytes, w_row;
  logic [LW-1:0] w_lane;
  logic [31:0] w_slot_base, w_addr;
  desc_t       w_desc, w_fifo_dout;
  logic        w_fifo_vld;
  logic        w_unused;

  assign w_unused    = ^s_axis_eth_tuser;
  assign w_init_any  = init_i | r_init_pend;
  // Pointers carry a wrap bit, so occupancy is their difference and the
  // ring is full exactly when the top bit of that difference is set.
  assign w_used      = r_wr_ptr - r_rel_ptr;
  assign w_slot_free = ~w_used[PW];

  assign w_keep16    = 16'(s_axis_eth_tkeep);
  assign w_new_bytes = r_bytes + {11'd0, popcnt16(w_keep16)};
  assign w_over      = (w_new_bytes > 16'(SLOT_BYTES));
  assign w_err       = s_axis_eth_tuser[ERR_BIT];

  assign w_acc    = s_axis_eth_tvalid & w_tready;
  assign w_in_pkt = w_acc & ((r_state == ST_SOP) | (r_state == ST_DATA));
  // The beat that overflows the slot would address the next slot: not written.
  assign w_wr     = w_in_pkt & ~w_over;
  assign w_good   = w_in_pkt & s_axis_eth_tlast & ~w_over & ~w_err;
  assign w_drop   = w_in_pkt & (w_over | (s_axis_eth_tlast & w_err));
  assign w_rel    = pkt_release_i & (w_used != '0);

  assign w_lane      = (R > 1) ? r_beat[LW-1:0] : '0;
  assign w_row       = r_beat >> RSH;
  assign w_slot_base = 32'(r_wr_ptr[PW-1:0]) * 32'(SLOT_BYTES);
  assign w_addr      = w_slot_base + 32'(w_row) * 32'(RB);

  assign w_desc.addr = w_slot_base;
  assign w_desc.len  = w_new_bytes;

  // Ready decode: capture states stall while the ring is full; a pending
  // flush blocks everything for its one cycle.
  always_comb begin
    w_tready = 1'b0;
    case (r_state)
      ST_IDLE:         w_tready = 1'b1;
      ST_SOP, ST_DATA: w_tready = w_slot_free;
      ST_DROP:         w_tready = 1'b1;
      default:         w_tready = 1'b0;
    endcase
    if (r_init_pend) w_tready = 1'b0;
  end

  // Next-state logic; IDLE only leaves on a packet boundary.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:
        if (start_i && !w_init_any && (!s_axis_eth_tvalid || s_axis_eth_tlast))
          w_state_nxt = ST_SOP;
      ST_SOP, ST_DATA:
        if (w_acc) begin
          if (s_axis_eth_tlast) w_state_nxt = ST_SOP;
          else if (w_over)      w_state_nxt = ST_DROP;
          else                  w_state_nxt = ST_DATA;
        end
      ST_DROP:
        if (w_acc && s_axis_eth_tlast) w_state_nxt = ST_SOP;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (r_init_pend) w_state_nxt = ST_IDLE;
  end

  // State register and init latch; the flush runs the cycle after init_i.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_state     <= ST_IDLE;
      r_init_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_pend <= init_i & ~r_init_pend;
    end
  end

  // Per-packet byte and beat counters, cleared at every packet boundary.
  always_ff @(posedge axi_clk) begin
    if (axi_reset || r_init_pend) begin
      r_bytes <= '0;
      r_beat  <= '0;
    end else if (w_in_pkt) begin
      if (s_axis_eth_tlast || w_over) begin
        r_bytes <= '0;
        r_beat  <= '0;
      end else begin
        r_bytes <= w_new_bytes;
        r_beat  <= r_beat + 16'd1;
      end
    end
  end

  // Slot accounting: allocate on a good tlast, free on a release pulse.
  always_ff @(posedge axi_clk) begin
    if (axi_reset || r_init_pend) begin
      r_wr_ptr  <= '0;
      r_rel_ptr <= '0;
    end else begin
      if (w_good) r_wr_ptr  <= r_wr_ptr + 1'b1;
      if (w_rel)  r_rel_ptr <= r_rel_ptr + 1'b1;
    end
  end

  // Registered BRAM port; only the lane of the current beat is updated.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_addr <= '0;
      r_data <= '0;
      r_wea  <= '0;
      r_en   <= 1'b0;
    end else begin
      r_en  <= w_wr;
      r_wea <= '0;
      if (w_wr) begin
        r_addr <= w_addr;
        for (int l = 0; l < R; l++) begin
          if (w_lane == LW'(l)) begin
            r_data[l*S_WIDTH +: S_WIDTH] <= s_axis_eth_tdata;
            r_wea[l*KB +: KB]            <= s_axis_eth_tkeep;
          end
        end
      end
    end
  end

  // Saturating drop counter; survives a flush.
  always_ff @(posedge axi_clk) begin
    if (axi_reset)                 r_drop <= '0;
    else if (w_drop && !(&r_drop)) r_drop <= r_drop + 32'd1;
  end

  tx_desc_fifo #(.DEPTH(NB_TX_DESC)) u_desc_fifo (
    .clk   (axi_clk),
    .rst   (axi_reset),
    .flush (r_init_pend),
    .push  (w_good),
    .din   (w_desc),
    .pop   (pkt_valid_o & pkt_ready_i),
    .dout  (w_fifo_dout),
    .valid (w_fifo_vld)
  );

  assign s_axis_eth_tready = w_tready;
  assign clk_o        = axi_clk;
  assign addr_o       = r_addr;
  assign data_o       = r_data;
  assign wea_o        = r_wea;
  assign en_o         = r_en;
  assign wren_o       = |r_wea;
  assign pkt_valid_o  = w_fifo_vld;
  assign pkt_addr_o   = w_fifo_vld ? w_fifo_dout.addr : 32'd0;
  assign pkt_len_o    = w_fifo_vld ? w_fifo_dout.len  : 16'd0;
  assign slots_used_o = w_used;
  assign drop_cnt_o   = r_drop;

endmodule
